// File: rtl/key_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : key_scheduler_if
// Description : Command channel (valid/ready with key index and repeat flag)
//               between the key scheduler and its consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_scheduler_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_code;
    logic       cmd_repeat;

    modport master (
        output cmd_valid,
        output cmd_code,
        output cmd_repeat,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_code,
        input  cmd_repeat,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/key_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : key_scheduler
// Description : Four-key debouncer with auto-repeat, round-robin event
//               arbitration and a 4-entry command FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module key_scheduler #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic [3:0]   key_n,
    key_scheduler_if.master   cmd,
    output logic              overflow
);

    localparam int C_NKEYS    = 4;
    localparam int C_DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int C_HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int C_HOLD_W   = (C_HOLD_MAX > 1) ? $clog2(C_HOLD_MAX) : 1;

    localparam logic [C_DB_W-1:0]   C_DB_LAST     = C_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [C_HOLD_W-1:0] C_DELAY_LAST  = C_HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [C_HOLD_W-1:0] C_PERIOD_LAST = C_HOLD_W'(REPEAT_PERIOD - 1);

    // ------------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------------
    logic [3:0] r_sync1;
    logic [3:0] r_sync_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1    <= 4'b1111;
            r_sync_out <= 4'b1111;
        end else begin
            r_sync1    <= key_n;
            r_sync_out <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-key debounce and hold/repeat timing
    // ------------------------------------------------------------------------
    logic [3:0] w_stable;
    logic [3:0] w_press_evt;
    logic [3:0] w_rep_evt;
    logic [3:0] w_evt;

    for (genvar k = 0; k < C_NKEYS; k++) begin : g_key
        logic [C_DB_W-1:0]   r_db_cnt;
        logic [C_HOLD_W-1:0] r_hold_cnt;
        logic                r_stable;
        logic                r_stable_d;
        logic                r_rep_phase;
        logic                w_hold_hit;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_db_cnt    <= '0;
                r_stable    <= 1'b1;
                r_stable_d  <= 1'b1;
                r_hold_cnt  <= '0;
                r_rep_phase <= 1'b0;
            end else begin
                r_stable_d <= r_stable;

                if (r_sync_out[k] == r_stable) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == C_DB_LAST) begin
                    r_stable <= r_sync_out[k];
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end

                // Phase 0 times the initial delay, phase 1 the repeat period
                if (r_stable || w_press_evt[k]) begin
                    r_hold_cnt  <= '0;
                    r_rep_phase <= 1'b0;
                end else if (w_rep_evt[k]) begin
                    r_hold_cnt  <= '0;
                    r_rep_phase <= 1'b1;
                end else begin
                    r_hold_cnt  <= r_hold_cnt + 1'b1;
                end
            end
        end

        assign w_hold_hit     = r_rep_phase ? (r_hold_cnt == C_PERIOD_LAST)
                                            : (r_hold_cnt == C_DELAY_LAST);
        assign w_stable[k]    = r_stable;
        assign w_press_evt[k] = ~r_stable & r_stable_d;
        assign w_rep_evt[k]   = ~r_stable & ~w_press_evt[k] & w_hold_hit;
        assign w_evt[k]       = w_press_evt[k] | w_rep_evt[k];
    end

    // ------------------------------------------------------------------------
    // Round-robin grant into the FIFO
    // ------------------------------------------------------------------------
    logic [3:0] r_pending;
    logic [3:0] r_pend_flag;
    logic [1:0] r_last_grant;
    logic       r_overflow;
    logic [2:0] r_count;

    logic       w_grant_valid;
    logic [1:0] w_grant_idx;
    logic [3:0] w_grant_onehot;
    logic [3:0] w_drop;

    always_comb begin
        w_grant_valid  = 1'b0;
        w_grant_idx    = 2'd0;
        w_grant_onehot = 4'd0;
        if (r_count != 3'd4) begin
            for (int i = 1; i <= C_NKEYS; i++) begin
                if (!w_grant_valid && r_pending[r_last_grant + 2'(i)]) begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = r_last_grant + 2'(i);
                end
            end
        end
        if (w_grant_valid) begin
            w_grant_onehot = 4'(1) << w_grant_idx;
        end
    end

    // An event is lost only when its slot is occupied and not draining this cycle
    assign w_drop = w_evt & r_pending & ~w_grant_onehot;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending    <= 4'd0;
            r_pend_flag  <= 4'd0;
            r_last_grant <= 2'd3;
            r_overflow   <= 1'b0;
        end else begin
            for (int k = 0; k < C_NKEYS; k++) begin
                if (w_evt[k] && !w_drop[k]) begin
                    r_pending[k]   <= 1'b1;
                    r_pend_flag[k] <= w_rep_evt[k];
                end else if (w_grant_onehot[k]) begin
                    r_pending[k]   <= 1'b0;
                end
            end
            r_overflow <= |w_drop;
            if (w_grant_valid) begin
                r_last_grant <= w_grant_idx;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------------
    logic [2:0] r_fifo_mem [C_NKEYS];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic       w_push;
    logic       w_pop;
    logic       w_valid;

    assign w_valid = (r_count != 3'd0);
    assign w_push  = w_grant_valid;
    assign w_pop   = w_valid & cmd.cmd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
            for (int i = 0; i < C_NKEYS; i++) begin
                r_fifo_mem[i] <= 3'd0;
            end
        end else begin
            if (w_push) begin
                r_fifo_mem[r_wr_ptr] <= {w_grant_idx, r_pend_flag[w_grant_idx]};
                r_wr_ptr             <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign cmd.cmd_valid  = w_valid;
    assign cmd.cmd_code   = w_valid ? r_fifo_mem[r_rd_ptr][2:1] : 2'd0;
    assign cmd.cmd_repeat = w_valid ? r_fifo_mem[r_rd_ptr][0]   : 1'b0;
    assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: doc/key_scheduler.md
KEY_SCHEDULER -- requirements
Module: key_scheduler

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles needed to accept a key level change.
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, cycles from accepted press to first auto-repeat event.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000, cycles between subsequent auto-repeat events.
REQ-004 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port key_n, input, 4, raw asynchronous keys (0 = pressed, 1 = released).
REQ-007 SHALL have port cmd_valid, output, 1, FIFO head holds a command.
REQ-008 SHALL have port cmd_ready, input, 1, consumer accepts the head command.
REQ-009 SHALL have port cmd_code, output, 2, index of the key that generated the head command.
REQ-010 SHALL have port cmd_repeat, output, 1, head command is an auto-repeat (1) or an initial press (0).
REQ-011 SHALL have port overflow, output, 1, one-cycle pulse when a key event is dropped.

Function
REQ-012 SHALL pass each key_n bit through two flip-flops (sync_out) before any other use.
REQ-013 SHALL keep per key a debounced level `stable` and a counter that clears whenever sync_out equals stable, and otherwise increments; at the edge where the counter equals DEBOUNCE_CYCLES-1 and a mismatch persists, stable takes sync_out and the counter clears.
REQ-014 SHALL detect a press event when stable is 0 and its one-cycle-delayed copy is 1; release produces no event.
REQ-015 SHALL run per key a hold counter that clears on a press event, counts while stable is 0, and clears on release; it SHALL raise a repeat event at count REPEAT_DELAY-1 and then every REPEAT_PERIOD cycles while held.
REQ-016 SHALL latch each event into pending[k] with a repeat-flag bit at the next edge.
REQ-017 SHALL, if an event arrives for key k while pending[k] is set and not being granted that cycle, drop the event, keep the existing pending entry unchanged, and pulse overflow for one cycle.
REQ-018 SHALL grant one pending key per cycle, and only when the FIFO is not full, searching round-robin from (last_grant+1) mod 4; a grant writes {k, flag} to the FIFO, clears pending[k], and sets last_grant to k.
REQ-019 SHALL allow an event to set pending[k] in the same cycle that pending[k] is granted and cleared; the new event then stays pending.
REQ-020 SHALL buffer commands in a 4-entry FIFO with wrapping 2-bit read and write pointers and a 3-bit count.
REQ-021 SHALL drive cmd_valid = (count != 0), with cmd_code and cmd_repeat taken from the head entry and held stable while cmd_valid=1 and cmd_ready=0.
REQ-022 SHALL pop on an edge where cmd_valid and cmd_ready are both 1; a simultaneous push and pop leaves count unchanged.
REQ-023 SHALL not push while count==4 even if a pop occurs that cycle; pending bits wait for the next cycle.
REQ-024 SHALL give a latency of exactly DEBOUNCE_CYCLES+4 rising edges from the first edge that samples key_n[k]=0 to cmd_valid=1, when the key is isolated, the FIFO is empty and nothing is pending.

Reset
REQ-025 SHALL, on an edge with rst_n=0, set the sync flops and stable to 4'b1111, clear all counters, pending, FIFO pointers and count, set last_grant=3, and drive cmd_valid=0, cmd_code=0, cmd_repeat=0, overflow=0.
REQ-026 SHALL treat a key held low through reset as a new press, giving a press event after the debounce time once rst_n=1; any commands queued before reset are lost.

Verification
REQ-027 Single press: DEBOUNCE_CYCLES=4; hold key_n=4'b1011 -> cmd_valid=1, cmd_code=2, cmd_repeat=0 after 8 edges; ready=1 pops it and cmd_valid=0 next cycle.
REQ-028 Bounce: toggle key_n[0] every 2 cycles for 20 cycles with DEBOUNCE_CYCLES=4, then release -> no command and no overflow.
REQ-029 Simultaneous: all four keys fall in the same cycle after reset -> commands come out in the order 0,1,2,3 with cmd_ready=1.
REQ-030 Auto-repeat: DEBOUNCE=4, REPEAT_DELAY=10, REPEAT_PERIOD=5; hold key 1 for 30 cycles -> commands (1,0), then (1,1) 10 cycles after the press and every 5 cycles after that, stopping on release.
REQ-031 Full/overflow: cmd_ready=0; cause 4 presses, then 2 more events on key 3 -> FIFO holds 4 entries, pending[3] is set, one overflow pulse; after cmd_ready=1 the fifth command (3) appears.
REQ-032 Reset mid-operation: with the FIFO holding 3 entries, assert rst_n=0 for 1 cycle while key 0 is held -> cmd_valid=0 at once, then a single (0,0) command after DEBOUNCE_CYCLES+4 edges.
